// File: rtl/sequenciador_apresentacao.sv
// Plays back the stored sequence for the current round: for each step it lights the LEDs
// and drives the buzzer for T_ON cycles, then leaves a T_OFF dark gap before the next step.
//
// state    | meaning
// OCIOSO   | idle, waiting for iniciar
// ENDERECA | present endereco to the sequence ROM
// LE       | capture ROM data into led_reg, load the step and buzzer timers
// ACENDE   | step lit, buzzer active, T_ON cycles
// APAGA    | dark gap between steps, T_OFF cycles
// FIM      | one-cycle pronto pulse
module sequenciador_apresentacao #(
  parameter int T_ON      = 5000,
  parameter int T_OFF     = 2500,
  parameter int BUZZ_HALF = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] rodada,
  input  logic       abortar,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       pulso_buzzer,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(BUZZ_HALF * 4 + 1);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ENDERECA = 3'd1,
    LE       = 3'd2,
    ACENDE   = 3'd3,
    APAGA    = 3'd4,
    FIM      = 3'd5
  } estado_t;

  estado_t         estado, proximo;
  logic [3:0]      endereco;
  logic [3:0]      rodada_reg;
  logic [3:0]      led_reg;
  logic [CW-1:0]   step_cnt;
  logic [BW-1:0]   buz_cnt;
  logic            buz_reg;
  logic            step_tc;
  logic            ultimo_passo;

  // Reload value for the buzzer timer: half-period scales with the lowest lit button.
  function automatic logic [BW-1:0] recarga_buzzer(input logic [3:0] d);
    logic [BW-1:0] r;
    if (d[0])      r = BW'(BUZZ_HALF - 1);
    else if (d[1]) r = BW'(BUZZ_HALF * 2 - 1);
    else if (d[2]) r = BW'(BUZZ_HALF * 3 - 1);
    else if (d[3]) r = BW'(BUZZ_HALF * 4 - 1);
    else           r = BW'(BUZZ_HALF - 1);
    return r;
  endfunction

  assign step_tc      = (step_cnt == '0);
  assign ultimo_passo = (endereco == rodada_reg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= proximo;
  end

  always_comb begin
    proximo      = estado;
    leds         = 4'd0;
    pulso_buzzer = 1'b0;
    pronto       = 1'b0;
    ocupado      = (estado != OCIOSO);
    db_estado    = {1'b0, estado};
    mem_endereco = endereco;

    case (estado)
      OCIOSO:   if (iniciar) proximo = ENDERECA;
      ENDERECA: proximo = LE;
      LE:       proximo = ACENDE;
      ACENDE: begin
        leds         = led_reg;
        pulso_buzzer = buz_reg;
        if (step_tc) proximo = ultimo_passo ? FIM : APAGA;
      end
      APAGA:    if (step_tc) proximo = ENDERECA;
      FIM: begin
        pronto  = 1'b1;
        proximo = OCIOSO;
      end
      default:  proximo = OCIOSO;
    endcase

    if (abortar) proximo = OCIOSO;
  end

  // Datapath freezes on abort so a cancelled gap never advances the address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      endereco   <= 4'd0;
      rodada_reg <= 4'd0;
      led_reg    <= 4'd0;
      step_cnt   <= '0;
      buz_cnt    <= '0;
      buz_reg    <= 1'b0;
    end else if (!abortar) begin
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            rodada_reg <= rodada;
            endereco   <= 4'd0;
          end
        end
        LE: begin
          led_reg  <= mem_dado;
          step_cnt <= CW'(T_ON - 1);
          buz_cnt  <= recarga_buzzer(mem_dado);
          buz_reg  <= 1'b0;
        end
        ACENDE: begin
          if (step_tc) begin
            if (!ultimo_passo) step_cnt <= CW'(T_OFF - 1);
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
          if (buz_cnt == '0) begin
            buz_cnt <= recarga_buzzer(led_reg);
            if (led_reg != 4'd0) buz_reg <= ~buz_reg;
          end else begin
            buz_cnt <= buz_cnt - 1'b1;
          end
        end
        APAGA: begin
          if (step_tc) endereco <= endereco + 4'd1;
          else         step_cnt <= step_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
